simon_seq_player: RTL and testbench

SIMON_SEQ_PLAYER -- requirements
Module: simon_seq_player

---
 rtl/simon_seq_player.sv | 150 +++++++++++++++
 tb/tb_simon_seq_player.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/simon_seq_player.sv
// Simon-style sequence player: stores random 2-bit colours drawn from a free-running
// LFSR and plays them back as timed lit/dark steps on the colour/enable outputs.
module simon_seq_player #(
  parameter int unsigned MS_CYCLES = 50000,
  parameter int unsigned ON_MS     = 400,
  parameter int unsigned OFF_MS    = 200,
  parameter int unsigned MAX_LEN   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       append,
  input  logic       clear,
  output logic [1:0] color,
  output logic       enable,
  output logic       busy,
  output logic       done,
  output logic [4:0] seq_len,
  output logic       full
);

  localparam int unsigned IDXW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TW   = 32;
  localparam logic [TW-1:0] ON_LAST  = TW'(ON_MS * MS_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_MS * MS_CYCLES - 1);
  localparam logic [4:0]    LEN_MAX  = 5'(MAX_LEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_OFF  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]      r_state;
  logic [TW-1:0]   r_timer;
  logic [IDXW-1:0] r_idx;
  logic [4:0]      r_seq_len;
  logic [15:0]     r_lfsr;
  logic [1:0]      r_mem [MAX_LEN];
  logic [1:0]      r_color;
  logic            r_enable;
  logic            r_busy;
  logic            r_done;
  logic            r_full;

  logic [1:0]      w_state_nxt;
  logic [TW-1:0]   w_timer_nxt;
  logic [IDXW-1:0] w_idx_nxt;
  logic [4:0]      w_seq_len_nxt;
  logic            w_wr_en;
  logic            w_fb;
  logic [1:0]      w_color_nxt;
  logic            w_enable_nxt;
  logic            w_busy_nxt;
  logic            w_done_nxt;
  logic            w_full_nxt;

  // Fibonacci taps 16,14,13,11 in right-shift form
  assign w_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  // Next-state, counters and registered-output values
  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer + TW'(1);
    w_idx_nxt     = r_idx;
    w_seq_len_nxt = r_seq_len;
    w_wr_en       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_timer_nxt = '0;
        if (clear) begin
          w_seq_len_nxt = '0;
        end else if (start) begin
          w_idx_nxt   = '0;
          w_state_nxt = (r_seq_len != 5'd0) ? S_ON : S_DONE;
        end else if (append && !r_full) begin
          w_wr_en       = 1'b1;
          w_seq_len_nxt = r_seq_len + 5'd1;
        end
      end
      S_ON: begin
        if (r_timer == ON_LAST) begin
          w_timer_nxt = '0;
          w_state_nxt = S_OFF;
        end
      end
      S_OFF: begin
        if (r_timer == OFF_LAST) begin
          w_timer_nxt = '0;
          if ((5'(r_idx) + 5'd1) < r_seq_len) begin
            w_idx_nxt   = r_idx + IDXW'(1);
            w_state_nxt = S_ON;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      default: begin
        w_timer_nxt = '0;
        w_state_nxt = S_IDLE;
      end
    endcase

    w_enable_nxt = (w_state_nxt == S_ON);
    w_color_nxt  = w_enable_nxt ? r_mem[w_idx_nxt] : 2'b00;
    w_busy_nxt   = (w_state_nxt == S_ON) || (w_state_nxt == S_OFF);
    w_done_nxt   = (w_state_nxt == S_DONE);
    w_full_nxt   = (w_seq_len_nxt == LEN_MAX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_idx     <= '0;
      r_seq_len <= '0;
      r_lfsr    <= 16'hACE1;
      r_color   <= 2'b00;
      r_enable  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_full    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_idx     <= w_idx_nxt;
      r_seq_len <= w_seq_len_nxt;
      r_lfsr    <= {w_fb, r_lfsr[15:1]};
      r_color   <= w_color_nxt;
      r_enable  <= w_enable_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_full    <= w_full_nxt;
    end
  end

  // Sequence memory holds no reset; contents beyond seq_len are don't-care
  always_ff @(posedge clk) begin
    if (rst_n && w_wr_en) begin
      r_mem[r_seq_len[IDXW-1:0]] <= r_lfsr[1:0];
    end
  end

  assign color   = r_color;
  assign enable  = r_enable;
  assign busy    = r_busy;
  assign done    = r_done;
  assign seq_len = r_seq_len;
  assign full    = r_full;

endmodule

// File: tb/tb_simon_seq_player.sv
// Bench for simon_seq_player: command table, directed playback corner cases and
// random command streams checked against a queue-based model of the sequence.
module tb_simon_seq_player;

  localparam int unsigned ON_CYC  = 8;
  localparam int unsigned OFF_CYC = 4;
  localparam int unsigned STEP    = ON_CYC + OFF_CYC;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, append, clear;
  logic [1:0] color;
  logic       enable, busy, done, full;
  logic [4:0] seq_len;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] m_lfsr;
  logic [1:0]  q[$];

  typedef struct {
    logic ap;
    logic cl;
    int   exp_len;
    logic exp_full;
  } vec_t;
  vec_t vecs[18];

  simon_seq_player #(.MS_CYCLES(4), .ON_MS(2), .OFF_MS(1), .MAX_LEN(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .append(append), .clear(clear),
    .color(color), .enable(enable), .busy(busy), .done(done),
    .seq_len(seq_len), .full(full)
  );

  always #5 clk = ~clk;

  // Reference LFSR: seeded in reset, otherwise one Fibonacci step per clock
  always @(posedge clk) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One IDLE-state command; the model follows clear > start > append
  task automatic cmd(input logic ap, input logic cl);
    append = ap;
    clear  = cl;
    if (cl) q.delete();
    else if (ap && q.size() < 16) q.push_back(m_lfsr[1:0]);
    tick();
    append = 1'b0;
    clear  = 1'b0;
  endtask

  // Start playback and check every cycle through done and back to IDLE
  task automatic play_check(input logic ap_with_start, input logic inject);
    int len, last, step, pos;
    len  = q.size();
    last = int'(STEP) * len + 2;
    start  = 1'b1;
    append = ap_with_start;
    tick();
    start  = 1'b0;
    append = 1'b0;
    for (int c = 1; c <= last; c++) begin
      if (c <= int'(STEP) * len) begin
        step = (c - 1) / int'(STEP);
        pos  = (c - 1) % int'(STEP);
        chk($sformatf("play c%0d enable", c), int'(enable), (pos < int'(ON_CYC)) ? 1 : 0);
        chk($sformatf("play c%0d color", c), int'(color), (pos < int'(ON_CYC)) ? int'(q[step]) : 0);
        chk($sformatf("play c%0d busy", c), int'(busy), 1);
        chk($sformatf("play c%0d done", c), int'(done), 0);
      end else begin
        chk($sformatf("play c%0d enable", c), int'(enable), 0);
        chk($sformatf("play c%0d busy", c), int'(busy), 0);
        chk($sformatf("play c%0d done", c), int'(done), (c == last - 1) ? 1 : 0);
      end
      chk($sformatf("play c%0d seq_len", c), int'(seq_len), len);
      chk($sformatf("play c%0d full", c), int'(full), (len == 16) ? 1 : 0);
      if (inject && c == 3) begin
        append = 1'b1;
        clear  = 1'b1;
      end else begin
        append = 1'b0;
        clear  = 1'b0;
      end
      if (c < last) tick();
    end
  endtask

  task automatic check_idle_quiet(input string name, input int cycles, input int len);
    for (int c = 0; c < cycles; c++) begin
      chk($sformatf("%s enable", name), int'(enable), 0);
      chk($sformatf("%s busy", name), int'(busy), 0);
      chk($sformatf("%s done", name), int'(done), 0);
      chk($sformatf("%s seq_len", name), int'(seq_len), len);
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; append = 1'b0; clear = 1'b0;
    tick(); tick();
    chk("reset color", int'(color), 0);
    chk("reset enable", int'(enable), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset seq_len", int'(seq_len), 0);
    chk("reset full", int'(full), 0);
    rst_n = 1'b1;
    tick(); tick();

    // Three appends, then full timed playback
    for (int i = 0; i < 3; i++) cmd(1'b1, 1'b0);
    chk("three appends seq_len", int'(seq_len), 3);
    play_check(1'b0, 1'b0);

    // Table: clear then 17 appends, saturating at 16
    vecs[0] = '{ap: 1'b0, cl: 1'b1, exp_len: 0, exp_full: 1'b0};
    for (int i = 1; i <= 17; i++)
      vecs[i] = '{ap: 1'b1, cl: 1'b0, exp_len: (i < 16) ? i : 16, exp_full: (i >= 16)};
    for (int i = 0; i < 18; i++) begin
      cmd(vecs[i].ap, vecs[i].cl);
      chk($sformatf("vec%0d seq_len", i), int'(seq_len), vecs[i].exp_len);
      chk($sformatf("vec%0d full", i), int'(full), int'(vecs[i].exp_full));
    end
    play_check(1'b0, 1'b0);

    // Start with empty sequence goes straight to done
    cmd(1'b0, 1'b1);
    chk("clear seq_len", int'(seq_len), 0);
    play_check(1'b0, 1'b0);

    // clear+start+append together: clear wins, no playback
    cmd(1'b1, 1'b0);
    cmd(1'b1, 1'b0);
    start = 1'b1; append = 1'b1; clear = 1'b1;
    q.delete();
    tick();
    start = 1'b0; append = 1'b0; clear = 1'b0;
    check_idle_quiet("combo clear", 15, 0);

    // start+append: start wins and length is unchanged
    cmd(1'b1, 1'b0);
    cmd(1'b1, 1'b0);
    play_check(1'b1, 1'b0);
    chk("start+append seq_len", int'(seq_len), 2);

    // append and clear pulsed during ON are ignored
    play_check(1'b0, 1'b1);
    chk("inject seq_len", int'(seq_len), 2);

    // Reset in the 5th ON cycle of step 1 aborts playback
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    chk("pre-reset enable", int'(enable), 1);
    rst_n = 1'b0;
    q.delete();
    tick();
    chk("abort enable", int'(enable), 0);
    chk("abort busy", int'(busy), 0);
    chk("abort seq_len", int'(seq_len), 0);
    chk("abort done", int'(done), 0);
    chk("abort color", int'(color), 0);
    rst_n = 1'b1;
    check_idle_quiet("post-abort", 20, 0);

    // Random command streams with occasional playback
    for (int it = 0; it < 40; it++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op < 6)       cmd(1'b1, 1'b0);
      else if (op == 6) cmd(1'b0, 1'b1);
      else if (op == 7) cmd(1'b1, 1'b1);
      else              play_check(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      chk($sformatf("rand%0d seq_len", it), int'(seq_len), q.size());
      chk($sformatf("rand%0d full", it), int'(full), (q.size() == 16) ? 1 : 0);
    end
    play_check(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
